qsys_system_leds: RTL and testbench

Avalon-MM slave output port for the Qsys system: software drives `out_port` (alarm/status LEDs, buzzer enable) through a data register with atomic set/clear, hardware per-bit blinking, and a timed one-shot pulse that raises an interrupt on completion. It is the write-side counterpart of the button input port, sits on the same HPS/Nios peripheral bus, and uses the same registered-read, one-cycle-latency slave timing.

---
 rtl/qsys_system_leds.sv | 149 ++++++++++++++
 tb/tb_qsys_system_leds.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_system_leds.sv
// Avalon-MM LED/buzzer output port: data register with atomic set/clear,
// per-bit hardware blinking and a tick-timed one-shot pulse with a done interrupt.
module qsys_system_leds #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} pulse_state_e;

  pulse_state_e     state_q, state_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] blink_mask_q, blink_mask_d;
  logic [15:0]      period_q, period_d;
  logic [15:0]      blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic [15:0]      pulse_cnt_q, pulse_cnt_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] out_port_q, out_port_d;

  logic             wr, tick, done_set;
  logic [WIDTH-1:0] wd;
  logic [15:0]      pulse_len;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign pulse_len = writedata[31:16];

  always_comb begin
    tick      = (pre_cnt_q == PW'(PRESCALE - 1));
    pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);

    data_d       = data_q;
    blink_mask_d = blink_mask_q;
    period_d     = period_q;
    irq_en_d     = irq_en_q;
    if (wr) begin
      case (address)
        3'd0:    data_d       = wd;
        3'd1:    data_d       = data_q | wd;
        3'd2:    data_d       = data_q & ~wd;
        3'd3:    blink_mask_d = wd;
        3'd4:    period_d     = writedata[15:0];
        3'd7:    irq_en_d     = writedata[0];
        default: ;
      endcase
    end

    // A PERIOD write restarts the blink cycle in the lit phase.
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (wr && address == 3'd4) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (period_q == 16'd0) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == period_q) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // A PULSE write always beats the countdown, so a reload on the final tick sets no done.
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    pulse_mask_d = pulse_mask_q;
    done_set     = 1'b0;
    if (wr && address == 3'd5) begin
      pulse_mask_d = wd;
      pulse_cnt_d  = pulse_len;
      state_d      = (pulse_len != 16'd0) ? ACTIVE : IDLE;
    end else if (state_q == ACTIVE && tick) begin
      pulse_cnt_d = pulse_cnt_q - 16'd1;
      if (pulse_cnt_q == 16'd1) begin
        state_d  = IDLE;
        done_set = 1'b1;
      end
    end
    done_d = done_set || (done_q && !(wr && address == 3'd6));

    out_port_d = (data_q & ~(blink_mask_q & {WIDTH{~phase_q}})) |
                 ((state_q == ACTIVE) ? pulse_mask_q : '0);

    case (address)
      3'd0, 3'd1, 3'd2: readdata_d = 32'(data_q);
      3'd3:             readdata_d = 32'(blink_mask_q);
      3'd4:             readdata_d = {16'b0, period_q};
      3'd5:             readdata_d = {pulse_cnt_q, 16'(pulse_mask_q)};
      3'd6:             readdata_d = {30'b0, state_q == ACTIVE, done_q};
      default:          readdata_d = {31'b0, irq_en_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      data_q       <= '0;
      blink_mask_q <= '0;
      period_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      pulse_mask_q <= '0;
      pulse_cnt_q  <= '0;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      readdata_q   <= '0;
      out_port_q   <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      data_q       <= data_d;
      blink_mask_q <= blink_mask_d;
      period_q     <= period_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      pulse_mask_q <= pulse_mask_d;
      pulse_cnt_q  <= pulse_cnt_d;
      done_q       <= done_d;
      irq_en_q     <= irq_en_d;
      readdata_q   <= readdata_d;
      out_port_q   <= out_port_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_port_q;
  assign irq      = done_q && irq_en_q;

endmodule

// File: tb/tb_qsys_system_leds.sv
// Bench for qsys_system_leds: directed and random bus traffic, an event-time
// reference model feeding expected queues, and a negedge monitor comparing them.
module tb_qsys_system_leds;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;

  // Bus handshake: a write is accepted on any rising edge where chipselect=1 and
  // write_n=0; readdata is sampled one edge after address, with no wait states.

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [31:0]      readdata;
  logic             irq;
  logic [WIDTH-1:0] out_port;

  qsys_system_leds #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_out_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_irq_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  string       phase_name = "reset";

  // ---------------- reference model ----------------
  // Time is counted in edges since the last reset edge; ticks land on edges that are
  // multiples of PRESCALE. A pulse is an interval ending at the edge of its D-th tick.
  int          m_e = 0;
  logic [7:0]  m_data, m_bmask, m_pmask;
  logic [15:0] m_period;
  int          m_period_w, m_pw, m_pd, m_pend;
  logic        m_pon, m_done, m_irq_en;

  function automatic int ticks(input int a, input int b);
    return b / PRESCALE - a / PRESCALE;
  endfunction

  function automatic logic m_phase(input int e);
    if (m_period == 16'd0) return 1'b1;
    return ((ticks(m_period_w, e) / (int'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic [15:0] m_pcnt(input int e);
    if (!m_pon) return 16'd0;
    return 16'(m_pd - ticks(m_pw, e));
  endfunction

  function automatic logic [7:0] m_outport(input int e);
    logic [7:0] o;
    o = m_data;
    if (!m_phase(e)) o = o & ~m_bmask;
    if (m_pon) o = o | m_pmask;
    return o;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a, input int e);
    case (a)
      3'd0, 3'd1, 3'd2: return {24'b0, m_data};
      3'd3:             return {24'b0, m_bmask};
      3'd4:             return {16'b0, m_period};
      3'd5:             return {m_pcnt(e), 8'b0, m_pmask};
      3'd6:             return {30'b0, m_pon, m_done};
      default:          return {31'b0, m_irq_en};
    endcase
  endfunction

  always @(posedge clk) begin
    int          e;
    logic [15:0] dv;
    if (!reset_n) begin
      m_e = 0; m_data = 0; m_bmask = 0; m_pmask = 0; m_period = 0; m_period_w = 0;
      m_pw = 0; m_pd = 0; m_pend = 0; m_pon = 0; m_done = 0; m_irq_en = 0;
      exp_out_q.push_back(32'd0);
      exp_rd_q.push_back(32'd0);
      exp_irq_q.push_back(32'd0);
    end else begin
      e = m_e + 1;
      exp_out_q.push_back({24'b0, m_outport(m_e)});
      exp_rd_q.push_back(m_read(address, m_e));
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd1: m_data = m_data | writedata[7:0];
          3'd2: m_data = m_data & ~writedata[7:0];
          3'd3: m_bmask = writedata[7:0];
          3'd4: begin m_period = writedata[15:0]; m_period_w = e; end
          3'd5: begin
            m_pmask = writedata[7:0];
            dv = writedata[31:16];
            if (dv != 16'd0) begin
              m_pon = 1'b1; m_pw = e; m_pd = int'(dv);
              m_pend = (e / PRESCALE + m_pd) * PRESCALE;
            end else begin
              m_pon = 1'b0;
            end
          end
          3'd6: m_done = 1'b0;
          default: m_irq_en = writedata[0];
        endcase
      end
      if (m_pon && m_pend <= e) begin
        m_pon  = 1'b0;
        m_done = 1'b1;
      end
      m_e = e;
      exp_irq_q.push_back({31'b0, m_done & m_irq_en});
    end
  end

  // ---------------- monitor ----------------
  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%s] t=%0t: got 0x%08h expected 0x%08h", what, phase_name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_out_q.size() > 0) check("out_port", {24'b0, out_port}, exp_out_q.pop_front());
    if (exp_rd_q.size() > 0)  check("readdata", readdata, exp_rd_q.pop_front());
    if (exp_irq_q.size() > 0) check("irq", {31'b0, irq}, exp_irq_q.pop_front());
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic rst_n, input logic [2:0] a, input logic wr, input logic [31:0] d);
    @(negedge clk);
    reset_n   = rst_n;
    address   = a;
    writedata = d;
    if (wr) begin
      chipselect = 1'b1; write_n = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      chipselect = 1'b1; write_n = 1'b1;
    end else begin
      chipselect = 1'b0; write_n = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    drive(1'b1, a, 1'b1, d);
  endtask

  task automatic idle(input int n, input logic [2:0] a);
    repeat (n) drive(1'b1, a, 1'b0, $urandom);
  endtask

  // Idles so that the next drive lands exactly on edge t.
  task automatic idle_until(input int t, input logic [2:0] a);
    int guard = 0;
    while (m_e + 2 < t && guard < 2000) begin
      drive(1'b1, a, 1'b0, $urandom);
      guard++;
    end
  endtask

  function automatic logic [31:0] rand_wdata(input logic [2:0] a);
    if (a == 3'd5) return {16'($urandom_range(0, 3)), 8'($urandom), 8'($urandom)};
    if (a == 3'd4) return {16'($urandom), 16'($urandom_range(0, 3))};
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] a;
    int         r;

    repeat (3) drive(1'b0, 3'd0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0, $urandom);
    idle(2, 3'd6);

    phase_name = "readback";
    wr_reg(3'd0, 32'hFFFF_FFA5);
    idle(3, 3'd0);

    phase_name = "set_clear";
    wr_reg(3'd1, 32'h0000_000F);
    idle(2, 3'd1);
    wr_reg(3'd2, 32'h0000_00A0);
    idle(2, 3'd2);
    drive(1'b0, 3'd0, 1'b0, 32'd0);
    idle(3, 3'd0);

    phase_name = "blink";
    wr_reg(3'd0, 32'hFF);
    wr_reg(3'd3, 32'h01);
    wr_reg(3'd4, 32'd2);
    idle(30, 3'd0);
    wr_reg(3'd4, 32'd0);
    idle(10, 3'd4);

    phase_name = "pulse_irq";
    wr_reg(3'd7, 32'd1);
    wr_reg(3'd0, 32'd0);
    wr_reg(3'd5, {16'd3, 8'h00, 8'h80});
    idle(18, 3'd6);
    wr_reg(3'd6, 32'd0);
    idle(3, 3'd6);

    phase_name = "retrigger";
    wr_reg(3'd5, {16'd5, 8'h00, 8'h40});
    idle(1, 3'd5);
    idle_until((m_pw / PRESCALE + 2) * PRESCALE + 1, 3'd5);
    wr_reg(3'd5, {16'd5, 8'h00, 8'h40});
    idle(36, 3'd6);
    wr_reg(3'd6, 32'd0);

    phase_name = "cancel";
    wr_reg(3'd5, {16'd5, 8'h00, 8'h20});
    idle(5, 3'd5);
    wr_reg(3'd5, {16'd0, 8'h00, 8'h20});
    idle(30, 3'd6);

    phase_name = "status_collision";
    wr_reg(3'd5, {16'd2, 8'h00, 8'h10});
    idle(1, 3'd6);
    idle_until(m_pend, 3'd6);
    wr_reg(3'd6, 32'd0);
    idle(4, 3'd6);
    wr_reg(3'd6, 32'd0);

    phase_name = "pulse_collision";
    wr_reg(3'd5, {16'd2, 8'h00, 8'h10});
    idle(1, 3'd6);
    idle_until(m_pend, 3'd5);
    wr_reg(3'd5, {16'd3, 8'h00, 8'h08});
    idle(20, 3'd6);

    phase_name = "long_pulse";
    wr_reg(3'd5, {16'hFFFF, 8'h00, 8'h01});
    idle(12, 3'd5);
    wr_reg(3'd5, 32'd0);
    idle(3, 3'd6);

    phase_name = "random";
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      if (r < 2) drive(1'b0, a, 1'b0, $urandom);
      else if (r < 30) wr_reg(a, rand_wdata(a));
      else drive(1'b1, a, 1'b0, $urandom);
    end
    idle(3, 3'd6);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
